// File: rtl/seq_arb_pkg.sv
// Shared types and defaults for the round-robin "101" detector arbiter.
// Holds the controller state enum, the core state encoding and the core next-state helper.
package seq_arb_pkg;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_CLR    = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_REPORT = 3'd5
  } ctrl_state_e;

  // The encoding is Gray-ordered along the A->B->C->D match path.
  typedef enum logic [1:0] {
    CORE_A = 2'b00,
    CORE_B = 2'b01,
    CORE_C = 2'b11,
    CORE_D = 2'b10
  } core_state_e;

  function automatic core_state_e core_next(input core_state_e cur, input logic din);
    core_state_e nxt;
    case (cur)
      CORE_A:  nxt = din ? CORE_B : CORE_A;
      CORE_B:  nxt = din ? CORE_B : CORE_C;
      CORE_C:  nxt = din ? CORE_D : CORE_A;
      CORE_D:  nxt = din ? CORE_B : CORE_C;
      default: nxt = CORE_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Requester-side bundle of the arbiter: per-requester streams in, grant and report out.
interface seq_detect_arbiter_if
  import seq_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  bit_in;
  logic [NREQ-1:0]  bit_valid;
  logic [NREQ-1:0]  bit_last;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [CNT_W-1:0] match_cnt;
  logic             aborted;

  modport master (
    output req, bit_in, bit_valid, bit_last,
    input  gnt, busy, done, done_id, match_cnt, aborted
  );

  modport slave (
    input  req, bit_in, bit_valid, bit_last,
    output gnt, busy, done, done_id, match_cnt, aborted
  );

endinterface

// File: rtl/seq_detect_core.sv
// Shared 2-bit Moore "101" detector; advances only when en is high, hit while in D.
module seq_detect_core
  import seq_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic hit
);

  core_state_e state_q;
  core_state_e state_d;

  // Next detector state for the incoming bit.
  always_comb begin
    state_d = core_next(state_q, din);
  end

  // Detector state register; clear has priority over a qualified bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CORE_A;
    end else if (clr) begin
      state_q <= CORE_A;
    end else if (en) begin
      state_q <= state_d;
    end else begin
      state_q <= state_q;
    end
  end

  assign hit = (state_q == CORE_D);

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin owner of one shared "101" detector; counts hits per burst and reports them.
// Optional idle-bit timeout is compiled in with SEQ_ARB_TIMEOUT_EN.
module seq_detect_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic           clk,
  input logic           reset,
  seq_detect_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [NREQ-1:0]  GNT_ONE = NREQ'(1);
  localparam logic [IDW-1:0]   LAST_ID = IDW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("seq_detect_arbiter: parameter out of range");
  end

  ctrl_state_e      state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IDW-1:0]   gidx_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             busy_q;
  logic             done_q;
  logic [IDW-1:0]   done_id_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             adv_q;

  logic             pick_found_s;
  logic [IDW-1:0]   pick_idx_s;
  logic [IDW:0]     sum_s;
  logic             core_clr_s;
  logic             core_en_s;
  logic             core_din_s;
  logic             core_last_s;
  logic             core_hit_s;
  logic [IDW-1:0]   rr_next_s;

`ifdef SEQ_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             abort_q;
`endif

  assign core_clr_s  = (state_q == S_CLR);
  assign core_en_s   = (state_q == S_RUN) && bus.bit_valid[gidx_q];
  assign core_din_s  = bus.bit_in[gidx_q];
  assign core_last_s = bus.bit_last[gidx_q];
  assign rr_next_s   = (gidx_q == LAST_ID) ? {IDW{1'b0}} : gidx_q + IDW'(1);

  seq_detect_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr_s),
    .en    (core_en_s),
    .din   (core_din_s),
    .hit   (core_hit_s)
  );

  // First asserted request at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IDW{1'b0}};
    sum_s        = {(IDW + 1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
      if (sum_s >= (IDW + 1)'(NREQ)) begin
        sum_s = sum_s - (IDW + 1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      if (!pick_found_s && bus.req[sum_s[IDW-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = sum_s[IDW-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // A hit counts once, on the cycle after the valid bit that moved the core into D.
  always_comb begin
    if (state_q == S_CLR) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (core_hit_s && adv_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Controller FSM with registered grant and report outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= {NREQ{1'b0}};
      gidx_q    <= {IDW{1'b0}};
      rr_ptr_q  <= {IDW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= {IDW{1'b0}};
      match_q   <= {CNT_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      adv_q     <= 1'b0;
`ifdef SEQ_ARB_TIMEOUT_EN
      tmr_q     <= {TMR_W{1'b0}};
      abort_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      adv_q  <= core_en_s;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ARB: begin
          if (pick_found_s) begin
            gnt_q   <= GNT_ONE << pick_idx_s;
            gidx_q  <= pick_idx_s;
            state_q <= S_CLR;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CLR: begin
          state_q <= S_RUN;
`ifdef SEQ_ARB_TIMEOUT_EN
          tmr_q   <= {TMR_W{1'b0}};
`endif
        end
        S_RUN: begin
          if (core_en_s && core_last_s) begin
            state_q <= S_DRAIN;
`ifdef SEQ_ARB_TIMEOUT_EN
          end else if (!core_en_s && (tmr_q == TMR_W'(TIMEOUT_CYC - 1))) begin
            state_q   <= S_REPORT;
            done_q    <= 1'b1;
            done_id_q <= gidx_q;
            match_q   <= cnt_d;
            abort_q   <= 1'b1;
`endif
          end else begin
            state_q <= S_RUN;
          end
`ifdef SEQ_ARB_TIMEOUT_EN
          tmr_q <= core_en_s ? {TMR_W{1'b0}} : tmr_q + TMR_W'(1);
`endif
        end
        S_DRAIN: begin
          state_q   <= S_REPORT;
          done_q    <= 1'b1;
          done_id_q <= gidx_q;
          match_q   <= cnt_d;
`ifdef SEQ_ARB_TIMEOUT_EN
          abort_q   <= 1'b0;
`endif
        end
        S_REPORT: begin
          state_q  <= S_IDLE;
          gnt_q    <= {NREQ{1'b0}};
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_next_s;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= {NREQ{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_q;
`ifdef SEQ_ARB_TIMEOUT_EN
  assign bus.aborted   = abort_q;
`else
  assign bus.aborted   = 1'b0;
`endif

endmodule
